// File: rtl/counter_arbiter.sv
// Round-robin arbiter that sequences one shared up-counter for NREQ requesters.
// Define COUNTER_ARBITER_FIXED_PRIO_EN to replace round-robin with lowest-index-wins priority.
module counter_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 4,
    localparam int unsigned OW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] len,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic [WIDTH-1:0]      count,
    output logic [OW-1:0]         owner
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  count_q, count_d;
    logic [WIDTH-1:0]  tgt_q, tgt_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic [OW-1:0]     ptr_q, ptr_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;

    logic [OW-1:0]     winner;
    logic [WIDTH-1:0]  len_arr [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            len_arr[i] = len[i*WIDTH +: WIDTH];
        end
    end

`ifdef COUNTER_ARBITER_FIXED_PRIO_EN
    // Descending scan: the last hit is the lowest set index.
    always_comb begin
        winner = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) winner = OW'(i);
        end
    end
`else
    localparam logic [OW:0] NREQ_V = (OW+1)'(NREQ);

    logic [NREQ-1:0] req_rot;
    logic [OW-1:0]   rr_off;
    logic [OW:0]     rr_sum;
    logic [OW-1:0]   next_ptr;

    // Rotate so bit 0 is the requester at ptr; first set bit gives the offset from ptr.
    assign req_rot = NREQ'({req, req} >> ptr_q);

    always_comb begin
        rr_off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_rot[i]) rr_off = OW'(i);
        end
    end

    assign rr_sum   = {1'b0, ptr_q} + {1'b0, rr_off};
    assign winner   = (rr_sum >= NREQ_V) ? OW'(rr_sum - NREQ_V) : rr_sum[OW-1:0];
    assign next_ptr = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tgt_d   = tgt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        done_d  = '0;

        unique case (state_q)
            StIdle: begin
                count_d = '0;
                gnt_d   = '0;
                if (|req) begin
                    owner_d = winner;
                    tgt_d   = len_arr[winner];
                    gnt_d   = NREQ'(1) << winner;
                    state_d = StRun;
                end
            end
            StRun: begin
                // Abort wins over the terminal compare.
                if (!req[owner_q]) begin
                    gnt_d   = '0;
                    count_d = '0;
`ifndef COUNTER_ARBITER_FIXED_PRIO_EN
                    ptr_d   = next_ptr;
`endif
                    state_d = StIdle;
                end else if (count_q == tgt_q) begin
                    gnt_d   = '0;
                    done_d  = NREQ'(1) << owner_q;
                    state_d = StDone;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            StDone: begin
                count_d = '0;
`ifndef COUNTER_ARBITER_FIXED_PRIO_EN
                ptr_d   = next_ptr;
`endif
                state_d = StIdle;
            end
            default: begin
                gnt_d   = '0;
                count_d = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            count_q <= '0;
            tgt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tgt_q   <= tgt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
        end
    end

    assign gnt   = gnt_q;
    assign done  = done_q;
    assign count = count_q;
    assign owner = owner_q;
    assign busy  = (state_q != StIdle);

endmodule
